requant_packer: RTL and testbench

//  Consumer end of the dense_25D output stream: takes NUM_TREES signed 32-bit sums per beat and

---
 rtl/requant_pkg.sv | 11 +
 rtl/requant_packer_if.sv | 11 +
 rtl/requant_fifo.sv | 38 +++
 rtl/requant_packer.sv | 76 +++++++
 tb/tb_requant_packer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/requant_pkg.sv
// requant_pkg: widths, pixel limits and lane saturation shared by the requant packer
package requant_pkg;
   localparam int SUM_W = 32;
   localparam int PIX_W = 8;
   localparam int PIX_MAX = 127;
   localparam int PIX_MIN = -128;
   function automatic logic signed [PIX_W-1:0] lane_sat(input logic signed [SUM_W:0] v);
      return v > (SUM_W+1)'(PIX_MAX) ? PIX_W'(PIX_MAX) :
             v < (SUM_W+1)'(PIX_MIN) ? PIX_W'(PIX_MIN) : v[PIX_W-1:0];
   endfunction
endpackage

// File: rtl/requant_packer_if.sv
// requant_packer_if: sum beats in, packed pixel vectors out with valid/ready
interface requant_packer_if #(parameter int NUM_TREES = 2);
   import requant_pkg::*;
   logic                       sums_valid;
   logic [SUM_W*NUM_TREES-1:0] sums_in;
   logic                       out_valid;
   logic                       out_ready;
   logic [PIX_W*NUM_TREES-1:0] pixel_vector_out;
   modport master(output sums_valid, sums_in, out_ready, input out_valid, pixel_vector_out);
   modport slave(input sums_valid, sums_in, out_ready, output out_valid, pixel_vector_out);
endinterface

// File: rtl/requant_fifo.sv
// requant_fifo: show-ahead FIFO; push while full is accepted only when a pop frees a slot
module requant_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
   // pointer update; the extra msb tells full from empty
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   // storage needs no reset: empty masks the read port
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/requant_packer.sv
// requant_packer: drop edge windows, round/shift/saturate sums to int8, queue packed vectors (RELU_EN clamps negatives)
module requant_packer import requant_pkg::*; #(
   parameter int NUM_TREES  = 2,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8,
   parameter int KERNEL_DIM = 4,
   parameter int SHIFT      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   requant_packer_if.slave  bus,
   output logic             frame_done,
   output logic             overflow
);
   localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
   localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
   localparam int VW = PIX_W * NUM_TREES;
   localparam logic signed [SUM_W:0] RND =
      SHIFT > 0 ? (SUM_W+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic last_col, last_row, keep, stg_valid, full, empty, pop;
   logic [VW-1:0] quant, stg_data;
   assign last_col = col == CW'(IMG_WIDTH - 1);
   assign last_row = row == RW'(IMG_HEIGHT - 1);
   assign keep = bus.sums_valid && int'(col) >= KERNEL_DIM - 1 && int'(row) >= KERNEL_DIM - 1;
   assign pop = bus.out_valid && bus.out_ready;
   assign bus.out_valid = !empty;
   for (genvar t = 0; t < NUM_TREES; t++) begin : g_lane
      logic signed [SUM_W:0] r, q;
      logic signed [PIX_W-1:0] s;
      assign r = $signed({bus.sums_in[SUM_W*t+SUM_W-1], bus.sums_in[SUM_W*t +: SUM_W]}) + RND;
      assign q = r >>> SHIFT;
      assign s = lane_sat(q);
`ifdef RELU_EN
      assign quant[PIX_W*t +: PIX_W] = s[PIX_W-1] ? '0 : s;
`else
      assign quant[PIX_W*t +: PIX_W] = s;
`endif
   end
   // raster position of the incoming beat; dropped beats still advance it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (bus.sums_valid) begin
         col <= last_col ? '0 : col + 1'b1;
         row <= last_col ? (last_row ? '0 : row + 1'b1) : row;
      end
   end
   // quantize stage, end-of-frame pulse and sticky drop flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stg_valid <= 1'b0;
         stg_data <= '0;
         frame_done <= 1'b0;
         overflow <= 1'b0;
      end else begin
         stg_valid <= keep;
         if (keep) stg_data <= quant;
         frame_done <= bus.sums_valid && last_col && last_row;
         if (stg_valid && full && !pop) overflow <= 1'b1;
      end
   end
   requant_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(VW)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(stg_valid),
      .pop(pop),
      .wdata(stg_data),
      .rdata(bus.pixel_vector_out),
      .full(full),
      .empty(empty)
   );
endmodule

// File: tb/tb_requant_packer.sv
// tb_requant_packer: scoreboard bench for requant_packer (default build and RELU_EN)
module tb_requant_packer;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic frame_done, overflow, frame_done0, overflow0;
   int errors = 0, checks = 0, pops = 0, pops0 = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp0_q[$];
   int sum_tbl[16] = '{1140, 1732, 5000, -5000, -100, 0, -1, 2031, 2040, -2048, -24, -25, 7, 8,
                       2147483647, 32'sh80000000};
   logic [7:0] exp_tbl[16] = '{8'h47, 8'h6C, 8'h7F, 8'h80, 8'hFA, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h80,
                               8'hFF, 8'hFE, 8'h00, 8'h01, 8'h7F, 8'h80};
   always #5 clock = ~clock;
   requant_packer_if #(.NUM_TREES(2)) bus();
   requant_packer_if #(.NUM_TREES(2)) bus0();
   requant_packer dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave),
      .frame_done(frame_done),
      .overflow(overflow)
   );
   requant_packer #(.NUM_TREES(2), .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_DIM(1), .SHIFT(0),
                    .FIFO_DEPTH(4)) dut0 (
      .clock(clock),
      .reset(reset),
      .bus(bus0.slave),
      .frame_done(frame_done0),
      .overflow(overflow0)
   );
   function automatic logic [7:0] relu8(input logic [7:0] x);
`ifdef RELU_EN
      return x[7] ? 8'h00 : x;
`else
      return x;
`endif
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask
   // scoreboard monitors: compare every accepted vector with the oldest expectation
   always @(negedge clock) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) check("unexpected_vec", {16'h0, bus.pixel_vector_out}, 32'hFFFF_FFFF);
         else check("vec", {16'h0, bus.pixel_vector_out}, {16'h0, exp_q.pop_front()});
         pops++;
      end
   end
   always @(negedge clock) begin
      if (reset && bus0.out_valid && bus0.out_ready) begin
         if (exp0_q.size() == 0) check("unexpected_vec0", {16'h0, bus0.pixel_vector_out}, 32'hFFFF_FFFF);
         else check("vec0", {16'h0, bus0.pixel_vector_out}, {16'h0, exp0_q.pop_front()});
         pops0++;
      end
   end
   task automatic run_beats(input int n, input int limit, input bit chk_valid, input bit chk_ovf);
      int kept = 0;
      bit prev_kept = 0;
      for (int b = 0; b < n; b++) begin
         int c, r;
         bit k;
         c = b % 8;
         r = (b / 8) % 8;
         k = c >= 3 && r >= 3;
         bus.sums_valid = 1'b1;
         bus.sums_in = {sum_tbl[(b + 5) % 16], sum_tbl[b % 16]};
         if (k && kept < limit) exp_q.push_back({relu8(exp_tbl[(b + 5) % 16]), relu8(exp_tbl[b % 16])});
         @(posedge clock);
         #1;
         check("frame_done", {31'h0, frame_done}, {31'h0, c == 7 && r == 7});
         if (chk_valid) check("out_valid_latency", {31'h0, bus.out_valid}, {31'h0, prev_kept});
         if (chk_ovf) check("overflow_rise", {31'h0, overflow}, {31'h0, kept >= 5});
         prev_kept = k;
         kept += int'(k);
      end
      bus.sums_valid = 1'b0;
   endtask
   initial begin
      int base;
      bus.sums_valid = 1'b0;
      bus.sums_in = '0;
      bus.out_ready = 1'b1;
      bus0.sums_valid = 1'b0;
      bus0.sums_in = '0;
      bus0.out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      check("rst_pixel", {16'h0, bus.pixel_vector_out}, 32'h0);
      check("rst_frame_done", {31'h0, frame_done}, 32'h0);
      check("rst_overflow", {31'h0, overflow}, 32'h0);
      reset = 1'b1;
      run_beats(64, 1000, 1, 0);
      @(posedge clock);
      #1;
      check("frame_done_one_cycle", {31'h0, frame_done}, 32'h0);
      repeat (4) @(posedge clock);
      #1;
      check("frame_vectors", pops, 25);
      check("frame_queue_empty", exp_q.size(), 0);
      check("no_overflow", {31'h0, overflow}, 32'h0);
      bus.out_ready = 1'b0;
      run_beats(64, 4, 0, 1);
      repeat (3) @(posedge clock);
      #1;
      check("ovf_sticky", {31'h0, overflow}, 32'h1);
      check("ovf_hold_valid", {31'h0, bus.out_valid}, 32'h1);
      check("ovf_hold_data", {16'h0, bus.pixel_vector_out}, {16'h0, exp_q[0]});
      base = pops;
      bus.out_ready = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      check("drain_count", pops - base, 4);
      check("drain_empty", {31'h0, bus.out_valid}, 32'h0);
      check("ovf_still_set", {31'h0, overflow}, 32'h1);
      run_beats(30, 1000, 1, 0);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      check("mid_rst_pixel", {16'h0, bus.pixel_vector_out}, 32'h0);
      check("mid_rst_frame_done", {31'h0, frame_done}, 32'h0);
      check("mid_rst_overflow", {31'h0, overflow}, 32'h0);
      exp_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b1;
      base = pops;
      run_beats(64, 1000, 1, 0);
      repeat (5) @(posedge clock);
      #1;
      check("post_rst_vectors", pops - base, 25);
      check("post_rst_queue_empty", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) begin
         logic [63:0] s;
         logic [15:0] e;
         s = i == 0 ? {32'hFFFF_FFFF, 32'd1140} : i == 1 ? {32'd1140, 32'hFFFF_FFFF} :
             i == 2 ? {32'hFFFF_FF80, 32'd127} : {32'hFFFF_FF7F, 32'd128};
         e = i == 0 ? 16'hFF7F : i == 1 ? 16'h7FFF : 16'h807F;
         bus0.sums_valid = 1'b1;
         bus0.sums_in = s;
         exp0_q.push_back({relu8(e[15:8]), relu8(e[7:0])});
         @(posedge clock);
         #1;
      end
      bus0.sums_valid = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("shift0_vectors", pops0, 4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
